adc_spi_scan: RTL and testbench
===============================

# adc_spi_scan

Parametrised SPI master for the MCP320x family of SAR ADCs (MCP3202 by default; MCP3204/3208 by parameter). It generates SCK from the system clock and builds the command frame. It converts one selected channel, or scans a channel mask once or continuously, and delivers each result with its channel tag and a one-cycle valid strobe. It sits between the ADC pins and the sample-processing logic.

## Interface
- DATA_W, 12: conversion result width.
- NUM_CH, 2: number of ADC channels.
- ADDR_W, 1: channel-address bits sent in the command (3 for MCP3204/3208).
- MSBF_EN, 1: append MSBF=1 command bit (MCP3202 only).
- GAP_BITS, 1: SCK periods between command and first data bit (sample + null; 2 for MCP3204/3208).
- CLK_DIV, 4: clk cycles per SCK half-period; must be ≥2.
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- start, in, 1: begin operation; sampled only while idle.
- scan, in, 1: 1 = scan ch_mask, 0 = single conversion of ch_sel.
- continuous, in, 1: repeat the scan until deasserted.
- diff_mode, in, 1: SGL/DIFF bit is driven as ~diff_mode.
- ch_sel, in, ADDR_W: channel for single mode.
- ch_mask, in, NUM_CH: enabled channels for scan mode.
- sdi, in, 1: ADC DOUT.
- sck, out, 1: SPI clock, mode 0, idles low.
- sdo, out, 1: ADC DIN.
- cs_n, out, 1: ADC chip select, active low.
- busy, out, 1: high from accepted start until the final frame's CS-high time ends.
- data_out, out, DATA_W: last result.
- data_ch, out, ADDR_W: channel of data_out.
- data_valid, out, 1: one-cycle strobe on new data_out.

## Operation
- Reset values: sck=0, sdo=0, cs_n=1, busy=0, data_valid=0, data_out=0, data_ch=0. Reset asserted mid-frame aborts the frame immediately and discards the partial result.
- Configuration latching: scan, diff_mode, ch_sel and ch_mask are latched at start. continuous is read live.
- Frame command: CMD_W = 2+ADDR_W+MSBF_EN. The command is, MSB first: 1 (start), ~diff_mode, channel[ADDR_W-1:0], then 1 if MSBF_EN.
- Frame length: F = CMD_W+GAP_BITS+DATA_W; default 17.
- SCK period k (k=0..F-1): sdo holds command bit k, or 0 once k ≥ CMD_W. sdo changes only while sck is low. sdi is sampled at the rising edge of period k.
- Data capture: bits from k=CMD_W+GAP_BITS to F-1 shift in MSB first. data_out and data_ch update only at frame end.
- States:
  - IDLE → CS_SETUP on start (when the start is valid).
  - CS_SETUP → SHIFT.
  - SHIFT → CS_HOLD after period F-1.
  - CS_HOLD → CS_SETUP if a next channel exists, else IDLE.
- Scan order: ascending channel index, skipping disabled channels.
  - After the highest enabled channel: if continuous=1, wrap to the lowest enabled channel; else finish.
  - continuous is read at the end of the last enabled channel's frame.
- Ignored starts: start while busy; start with scan=1 and ch_mask=0 (busy stays 0).
- Single mode: exactly one frame, independent of continuous.

## Timing
- Reference point: start is sampled high at clk edge 0 while idle.
- Cycle 1: cs_n falls and busy rises. sdo = command bit 0 and sck = 0 for CLK_DIV cycles (CS setup).
- Each SCK period is 2·CLK_DIV cycles: sck is high for the first CLK_DIV cycles and low for the second.
- First sck rise: cycle 1+CLK_DIV. Last rise: 1+CLK_DIV+(F-1)·2·CLK_DIV.
- cs_n rises CLK_DIV cycles after the last rise. data_valid pulses in that same cycle.
- cs_n stays high for 2·CLK_DIV cycles (CS_HOLD). The next frame's cs_n falls at the end of that window, or busy falls if no frame follows.
- Defaults: first rise at 5, last rise at 133, cs_n high and data_valid at 137, busy low or next cs_n low at 145.

## Test plan
- Default params; single mode, ch_sel=1, diff_mode=0; ADC model returns 0xA5C.
  - sdo bits 1,1,1,1 in periods 0–3.
  - data_out=0xA5C, data_ch=1, data_valid at cycle 137 only.
  - cs_n low for cycles 1–136; busy falls at 145.
- scan=1, ch_mask=2'b11, continuous=0; model returns ch0=0x123, ch1=0xFFF.
  - Two frames, valids tagged 0 then 1.
  - Frame 2 has cs_n low at 145. busy falls 8 cycles after the second frame's cs_n rises.
- scan=1, continuous=1, ch_mask=2'b10 → repeated ch1 frames 144 cycles apart. Drop continuous mid-frame → that frame completes, then idle.
- Reset asserted at cycle 60 → cs_n=1, sck=0 asynchronously, no data_valid, data_out stays 0. A new start then yields a full correct frame.
- Start while busy, and start with scan=1, ch_mask=0 → no frame, no state change.
- NUM_CH=8, ADDR_W=3, MSBF_EN=0, GAP_BITS=2; single, ch_sel=5, diff_mode=1.
  - F=19; sdo 1,0,1,0,1.
  - Result 0x800 captured; data_ch=5.

Source files
------------

// File: rtl/adc_spi_scan.sv
// SPI master for MCP320x SAR ADCs: single conversion or one-shot/continuous channel-mask scan.
// cs_n falls one cycle after an accepted start; results stream out with a one-cycle data_valid, no backpressure.
module adc_spi_scan #(
   parameter int DATA_W   = 12,
   parameter int NUM_CH   = 2,
   parameter int ADDR_W   = 1,
   parameter int MSBF_EN  = 1,
   parameter int GAP_BITS = 1,
   parameter int CLK_DIV  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              scan,
   input  logic              continuous,
   input  logic              diff_mode,
   input  logic [ADDR_W-1:0] ch_sel,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic              sdi,
   output logic              sck,
   output logic              sdo,
   output logic              cs_n,
   output logic              busy,
   output logic [DATA_W-1:0] data_out,
   output logic [ADDR_W-1:0] data_ch,
   output logic              data_valid
);

   localparam int CMD_W = 2 + ADDR_W + MSBF_EN;
   localparam int F     = CMD_W + GAP_BITS + DATA_W;
   localparam int CW    = $clog2(2 * CLK_DIV);
   localparam int KW    = $clog2(F);

   typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [KW-1:0]     k;
   logic              scan_q, diff_q, wrap_q;
   logic [NUM_CH-1:0] mask_q;
   logic [ADDR_W-1:0] ch_q;
   logic [CMD_W-1:0]  cmd_sr;
   logic [DATA_W-1:0] rx_sr;

   logic              first_ok, next_ok, low_ok;
   logic [ADDR_W-1:0] first_ch, next_ch, low_ch;
   logic              start_ok, has_next;
   logic [ADDR_W-1:0] start_ch, nxt_ch;

   function automatic logic [CMD_W-1:0] build_cmd(input logic diff, input logic [ADDR_W-1:0] ch);
      logic [CMD_W-1:0] c;
      c = '0;
      c[CMD_W-1] = 1'b1;
      c[CMD_W-2] = ~diff;
      c[CMD_W-3 -: ADDR_W] = ch;
      if (MSBF_EN != 0) c[0] = 1'b1;
      return c;
   endfunction

   // Descending loops leave the lowest qualifying index as the final assignment.
   always_comb begin
      first_ok = 1'b0;
      first_ch = '0;
      next_ok  = 1'b0;
      next_ch  = '0;
      low_ok   = 1'b0;
      low_ch   = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ch_mask[i]) begin
            first_ok = 1'b1;
            first_ch = ADDR_W'(i);
         end
         if (mask_q[i]) begin
            low_ok = 1'b1;
            low_ch = ADDR_W'(i);
            if (i > int'(ch_q)) begin
               next_ok = 1'b1;
               next_ch = ADDR_W'(i);
            end
         end
      end
   end

   assign start_ok = start && (!scan || first_ok);
   assign start_ch = scan ? first_ch : ch_sel;
   assign has_next = scan_q && (next_ok || (wrap_q && low_ok));
   assign nxt_ch   = next_ok ? next_ch : low_ch;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         k          <= '0;
         scan_q     <= 1'b0;
         diff_q     <= 1'b0;
         wrap_q     <= 1'b0;
         mask_q     <= '0;
         ch_q       <= '0;
         cmd_sr     <= '0;
         rx_sr      <= '0;
         sck        <= 1'b0;
         sdo        <= 1'b0;
         cs_n       <= 1'b1;
         busy       <= 1'b0;
         data_out   <= '0;
         data_ch    <= '0;
         data_valid <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start_ok) begin
                  scan_q <= scan;
                  diff_q <= diff_mode;
                  mask_q <= ch_mask;
                  ch_q   <= start_ch;
                  cmd_sr <= build_cmd(diff_mode, start_ch);
                  sdo    <= 1'b1;
                  cs_n   <= 1'b0;
                  busy   <= 1'b1;
                  cnt    <= '0;
                  state  <= CS_SETUP;
               end
            end
            CS_SETUP: begin
               if (cnt == CW'(CLK_DIV - 1)) begin
                  cnt   <= '0;
                  k     <= '0;
                  sck   <= 1'b1;
                  rx_sr <= {rx_sr[DATA_W-2:0], sdi};
                  state <= SHIFT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SHIFT: begin
               if (cnt == CW'(CLK_DIV - 1)) begin
                  cnt <= '0;
                  if (sck) begin
                     // Falling edge: present the next command bit; zeros shift in after the command.
                     sck    <= 1'b0;
                     cmd_sr <= cmd_sr << 1;
                     sdo    <= cmd_sr[CMD_W-2];
                     if (k == KW'(F - 1)) begin
                        sdo        <= 1'b0;
                        cs_n       <= 1'b1;
                        data_out   <= rx_sr;
                        data_ch    <= ch_q;
                        data_valid <= 1'b1;
                        wrap_q     <= continuous;
                        state      <= CS_HOLD;
                     end
                  end else begin
                     sck   <= 1'b1;
                     k     <= k + 1'b1;
                     rx_sr <= {rx_sr[DATA_W-2:0], sdi};
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            CS_HOLD: begin
               if (cnt == CW'(2 * CLK_DIV - 1)) begin
                  cnt <= '0;
                  if (has_next) begin
                     ch_q   <= nxt_ch;
                     cmd_sr <= build_cmd(diff_q, nxt_ch);
                     sdo    <= 1'b1;
                     cs_n   <= 1'b0;
                     state  <= CS_SETUP;
                  end else begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_spi_scan.sv
// Bench for adc_spi_scan: behavioural MCP320x models feed both a default and an 8-channel instance;
// expected results are queued at start and popped by monitors on data_valid.
module tb_adc_spi_scan;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Default instance (MCP3202)
   logic        start_a, scan_a, cont_a, diff_a, sdi_a;
   logic [0:0]  chsel_a;
   logic [1:0]  mask_a;
   logic        sck_a, sdo_a, cs_n_a, busy_a, dv_a;
   logic [11:0] dout_a;
   logic [0:0]  dch_a;

   adc_spi_scan dut_a (
      .clk(clk), .reset(reset), .start(start_a), .scan(scan_a), .continuous(cont_a),
      .diff_mode(diff_a), .ch_sel(chsel_a), .ch_mask(mask_a), .sdi(sdi_a),
      .sck(sck_a), .sdo(sdo_a), .cs_n(cs_n_a), .busy(busy_a),
      .data_out(dout_a), .data_ch(dch_a), .data_valid(dv_a)
   );

   // MCP3208-style instance
   logic        start_b, scan_b, cont_b, diff_b, sdi_b;
   logic [2:0]  chsel_b;
   logic [7:0]  mask_b;
   logic        sck_b, sdo_b, cs_n_b, busy_b, dv_b;
   logic [11:0] dout_b;
   logic [2:0]  dch_b;

   adc_spi_scan #(.DATA_W(12), .NUM_CH(8), .ADDR_W(3), .MSBF_EN(0), .GAP_BITS(2), .CLK_DIV(4)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .scan(scan_b), .continuous(cont_b),
      .diff_mode(diff_b), .ch_sel(chsel_b), .ch_mask(mask_b), .sdi(sdi_b),
      .sck(sck_b), .sdo(sdo_b), .cs_n(cs_n_b), .busy(busy_b),
      .data_out(dout_b), .data_ch(dch_b), .data_valid(dv_b)
   );

   // ADC models: period counter advances on sck fall, command bits captured on sck rise
   logic [11:0] adc_a [0:1];
   logic [11:0] adc_b [0:7];
   int          ka = 0, kb = 0;
   logic [3:0]  cap_a = '0;
   logic [4:0]  cap_b = '0;

   always @(negedge sck_a or posedge cs_n_a)
      if (cs_n_a) ka <= 0; else ka <= ka + 1;
   always @(posedge sck_a)
      if (ka < 4) cap_a <= {cap_a[2:0], sdo_a};
   always_comb begin
      sdi_a = 1'b0;
      if (ka >= 5 && ka < 17) sdi_a = adc_a[cap_a[1]][16-ka];
   end

   always @(negedge sck_b or posedge cs_n_b)
      if (cs_n_b) kb <= 0; else kb <= kb + 1;
   always @(posedge sck_b)
      if (kb < 5) cap_b <= {cap_b[3:0], sdo_b};
   always_comb begin
      sdi_b = 1'b0;
      if (kb >= 7 && kb < 19) sdi_b = adc_b[cap_b[2:0]][18-kb];
   end

   int n_pass = 0, n_total = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", nm, act, exp, cyc);
   endtask

   typedef struct { int cyc; int dat; int ch; int cmd; } exp_t;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;

   task automatic push_a(input int c, input int d, input int ch, input int cmd);
      qa.push_back(exp_t'{c, d, ch, cmd});
   endtask
   task automatic push_b(input int c, input int d, input int ch, input int cmd);
      qb.push_back(exp_t'{c, d, ch, cmd});
   endtask

   always @(negedge clk) begin
      if (dv_a === 1'b1) begin
         chk("a_valid_expected", int'(qa.size() > 0), 1);
         if (qa.size() > 0) begin
            ea = qa.pop_front();
            chk("a_valid_cycle", cyc, ea.cyc);
            chk("a_data", int'(dout_a), ea.dat);
            chk("a_ch", int'(dch_a), ea.ch);
            chk("a_cmd", int'(cap_a), ea.cmd);
         end
      end
   end

   always @(negedge clk) begin
      if (dv_b === 1'b1) begin
         chk("b_valid_expected", int'(qb.size() > 0), 1);
         if (qb.size() > 0) begin
            eb = qb.pop_front();
            chk("b_valid_cycle", cyc, eb.cyc);
            chk("b_data", int'(dout_b), eb.dat);
            chk("b_ch", int'(dch_b), eb.ch);
            chk("b_cmd", int'(cap_b), eb.cmd);
         end
      end
   end

   // Spec cycle c after start sampled at edge e0 is observed when cyc == e0 + c - 1.
   task automatic wait_to(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic go_a(input logic sc, input logic ct, input logic df, input logic [0:0] cs,
                       input logic [1:0] mk, output int e0);
      @(negedge clk);
      scan_a = sc; cont_a = ct; diff_a = df; chsel_a = cs; mask_a = mk; start_a = 1'b1;
      e0 = cyc + 1;
      @(negedge clk);
      start_a = 1'b0;
   endtask

   int e0;

   initial begin
      reset = 1'b1;
      start_a = 0; scan_a = 0; cont_a = 0; diff_a = 0; chsel_a = '0; mask_a = '0;
      start_b = 0; scan_b = 0; cont_b = 0; diff_b = 0; chsel_b = '0; mask_b = '0;
      adc_a[0] = 12'h123; adc_a[1] = 12'hA5C;
      for (int i = 0; i < 8; i++) adc_b[i] = 12'h000;
      adc_b[5] = 12'h800;
      repeat (3) @(negedge clk);
      chk("rst_sck", sck_a, 0);
      chk("rst_sdo", sdo_a, 0);
      chk("rst_cs_n", cs_n_a, 1);
      chk("rst_busy", busy_a, 0);
      chk("rst_valid", dv_a, 0);
      chk("rst_data_out", dout_a, 0);
      chk("rst_data_ch", dch_a, 0);
      chk("rst_b_cs_n", cs_n_b, 1);
      reset = 1'b0;
      @(negedge clk);

      // Reset asserted mid-frame aborts without a result
      go_a(0, 0, 0, 1'b0, 2'b00, e0);
      wait_to(e0 + 59);
      chk("abort_cs_n_low_before", cs_n_a, 0);
      #1 reset = 1'b1;
      #1;
      chk("abort_cs_n", cs_n_a, 1);
      chk("abort_sck", sck_a, 0);
      chk("abort_busy", busy_a, 0);
      chk("abort_data_out", dout_a, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (200) @(negedge clk);
      chk("abort_no_restart_cs_n", cs_n_a, 1);

      // Single conversion of ch1, with an ignored start mid-frame
      go_a(0, 0, 0, 1'b1, 2'b00, e0);
      push_a(e0 + 136, 'hA5C, 1, 'hF);
      chk("single_cs_n_c1", cs_n_a, 0);
      chk("single_busy_c1", busy_a, 1);
      wait_to(e0 + 3);
      chk("single_sck_c4", sck_a, 0);
      wait_to(e0 + 4);
      chk("single_sck_c5", sck_a, 1);
      wait_to(e0 + 49);
      chsel_a = 1'b0; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      wait_to(e0 + 135);
      chk("single_cs_n_c136", cs_n_a, 0);
      wait_to(e0 + 136);
      chk("single_cs_n_c137", cs_n_a, 1);
      wait_to(e0 + 143);
      chk("single_busy_c144", busy_a, 1);
      wait_to(e0 + 144);
      chk("single_busy_c145", busy_a, 0);
      repeat (20) @(negedge clk);

      // One-shot scan of both channels
      adc_a[1] = 12'hFFF;
      go_a(1, 0, 0, 1'b0, 2'b11, e0);
      push_a(e0 + 136, 'h123, 0, 'hD);
      push_a(e0 + 280, 'hFFF, 1, 'hF);
      wait_to(e0 + 143);
      chk("scan_cs_n_c144", cs_n_a, 1);
      wait_to(e0 + 144);
      chk("scan_cs_n_c145", cs_n_a, 0);
      wait_to(e0 + 287);
      chk("scan_busy_c288", busy_a, 1);
      wait_to(e0 + 288);
      chk("scan_busy_c289", busy_a, 0);
      repeat (20) @(negedge clk);

      // Continuous scan of ch1 only; drop continuous during the third frame
      adc_a[1] = 12'h5A3;
      go_a(1, 1, 0, 1'b0, 2'b10, e0);
      push_a(e0 + 136, 'h5A3, 1, 'hF);
      push_a(e0 + 280, 'h5A3, 1, 'hF);
      push_a(e0 + 424, 'h5A3, 1, 'hF);
      wait_to(e0 + 349);
      cont_a = 1'b0;
      wait_to(e0 + 431);
      chk("cont_busy_c432", busy_a, 1);
      wait_to(e0 + 432);
      chk("cont_busy_c433", busy_a, 0);
      chk("cont_cs_n_c433", cs_n_a, 1);
      repeat (20) @(negedge clk);

      // Empty-mask scan start is ignored
      go_a(1, 0, 0, 1'b0, 2'b00, e0);
      chk("empty_busy", busy_a, 0);
      chk("empty_cs_n", cs_n_a, 1);
      repeat (200) @(negedge clk);
      chk("empty_cs_n_later", cs_n_a, 1);

      // 8-channel variant: differential ch5
      @(negedge clk);
      scan_b = 0; diff_b = 1; chsel_b = 3'd5; start_b = 1'b1;
      e0 = cyc + 1;
      @(negedge clk);
      start_b = 1'b0;
      push_b(e0 + 152, 'h800, 5, 'h15);
      wait_to(e0 + 159);
      chk("b_busy_c160", busy_b, 1);
      wait_to(e0 + 160);
      chk("b_busy_c161", busy_b, 0);

      repeat (20) @(negedge clk);
      chk("a_queue_drained", qa.size(), 0);
      chk("b_queue_drained", qb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
